// File: rtl/uart_rx_if.sv
// Byte-side handshake and status bundle between uart_rx and its register-block consumer.
// The receiver drives the data and status (master); the consumer drives RX_READY/OVR_CLR.
interface uart_rx_if;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY;
    logic       FRAME_ERR;
    logic       PARITY_ERR;
    logic       OVERRUN;
    logic       OVR_CLR;

    modport master (
        output RX_DATA,
        output RX_VALID,
        input  RX_READY,
        output FRAME_ERR,
        output PARITY_ERR,
        output OVERRUN,
        input  OVR_CLR
    );

    modport slave (
        input  RX_DATA,
        input  RX_VALID,
        output RX_READY,
        input  FRAME_ERR,
        input  PARITY_ERR,
        input  OVERRUN,
        output OVR_CLR
    );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver (8N1) with a one-entry holding register.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx #(
    parameter int unsigned BAUD_DIV = 163
) (
    input  logic      CLK,
    input  logic      RESET,
    input  logic      RSRX,
    uart_rx_if.master rxBus
);

    localparam logic [15:0] BaudMax = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBreak
    } stateT;

    stateT       state;
    logic        sync1;
    logic        sync2;
    logic        rxPrev;
    logic        rxS;
    logic        startEdge;
    logic [15:0] baudCnt;
    logic        tick;
    logic [3:0]  tickCnt;
    logic [2:0]  bitIdx;
    logic [7:0]  shiftReg;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        frameErr;
    logic        overrun;
`ifdef UART_RX_PARITY_EN
    logic        parityBit;
    logic        parityErr;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            sync1  <= RSRX;
            sync2  <= sync1;
            rxPrev <= sync2;
        end
    end

    always_comb begin
        rxS       = sync2;
        startEdge = (state == StIdle) && rxPrev && !rxS;
        tick      = (baudCnt == BaudMax);
    end

    // Restarting the divider on the start edge puts every sample a fixed phase after the edge.
    always_ff @(posedge CLK) begin
        if (RESET || startEdge || tick) begin
            baudCnt <= 16'd0;
        end else begin
            baudCnt <= baudCnt + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= StIdle;
            tickCnt  <= 4'd0;
            bitIdx   <= 3'd0;
            shiftReg <= 8'h00;
            rxData   <= 8'h00;
            rxValid  <= 1'b0;
            frameErr <= 1'b0;
            overrun  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityBit <= 1'b0;
            parityErr <= 1'b0;
`endif
        end else begin
            frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityErr <= 1'b0;
`endif
            if (rxValid && rxBus.RX_READY) begin
                rxValid <= 1'b0;
            end

            case (state)
                StIdle: begin
                    tickCnt <= 4'd0;
                    if (startEdge) begin
                        state <= StStart;
                    end
                end

                StStart: begin
                    if (tick) begin
                        if (tickCnt == 4'd7) begin
                            tickCnt <= 4'd0;
                            bitIdx  <= 3'd0;
                            state   <= rxS ? StIdle : StData;
                        end else begin
                            tickCnt <= tickCnt + 4'd1;
                        end
                    end
                end

                StData: begin
                    if (tick) begin
                        tickCnt <= tickCnt + 4'd1;
                        if (tickCnt == 4'd15) begin
                            shiftReg <= {rxS, shiftReg[7:1]};
                            bitIdx   <= bitIdx + 3'd1;
                            if (bitIdx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= StParity;
`else
                                state <= StStop;
`endif
                            end
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (tick) begin
                        tickCnt <= tickCnt + 4'd1;
                        if (tickCnt == 4'd15) begin
                            parityBit <= rxS;
                            state     <= StStop;
                        end
                    end
                end
`endif

                StStop: begin
                    if (tick) begin
                        tickCnt <= tickCnt + 4'd1;
                        if (tickCnt == 4'd15) begin
                            if (rxS) begin
`ifdef UART_RX_PARITY_EN
                                if (parityBit != ^shiftReg) begin
                                    parityErr <= 1'b1;
                                end else
`endif
                                begin
                                    // A full register not drained this cycle drops the new byte.
                                    if (!rxValid || rxBus.RX_READY) begin
                                        rxData  <= shiftReg;
                                        rxValid <= 1'b1;
                                    end else begin
                                        overrun <= 1'b1;
                                    end
                                end
                                state <= StIdle;
                            end else begin
                                frameErr <= 1'b1;
                                state    <= StBreak;
                            end
                        end
                    end
                end

                StBreak: begin
                    tickCnt <= 4'd0;
                    if (rxS) begin
                        state <= StIdle;
                    end
                end

                default: state <= StIdle;
            endcase

            // Clear wins over a same-cycle overrun set.
            if (rxBus.OVR_CLR) begin
                overrun <= 1'b0;
            end
        end
    end

    assign rxBus.RX_DATA   = rxData;
    assign rxBus.RX_VALID  = rxValid;
    assign rxBus.FRAME_ERR = frameErr;
    assign rxBus.OVERRUN   = overrun;
`ifdef UART_RX_PARITY_EN
    assign rxBus.PARITY_ERR = parityErr;
`else
    assign rxBus.PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at BAUD_DIV=4: sent bytes are queued as expected,
// bytes accepted over the handshake are queued as received, and each test compares them.
module tb_uart_rx;

    localparam int unsigned Baud = 4;
    localparam int BitCyc = 16 * Baud;

    logic CLK = 1'b0;
    logic RESET;
    logic RSRX;

    uart_rx_if rxBus();

    uart_rx #(.BAUD_DIV(Baud)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .RSRX (RSRX),
        .rxBus(rxBus.master)
    );

    always #5 CLK = ~CLK;

    int nVec = 0;
    int nErr = 0;
    int nValidCyc = 0;
    int nFe = 0;
    int nPe = 0;
    logic [7:0] expQ[$];
    logic [7:0] rxQ[$];

    always @(negedge CLK) begin
        if (!RESET) begin
            if (rxBus.RX_VALID) nValidCyc++;
            if (rxBus.RX_VALID && rxBus.RX_READY) rxQ.push_back(rxBus.RX_DATA);
            if (rxBus.FRAME_ERR) nFe++;
            if (rxBus.PARITY_ERR) nPe++;
        end
    end

    task automatic waitCyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Leaves the line at the stop-bit level so a low stop can be extended by the caller.
    task automatic sendFrame(input logic [7:0] b, input logic par, input logic stopBit);
        RSRX = 1'b0;
        waitCyc(BitCyc);
        for (int i = 0; i < 8; i++) begin
            RSRX = b[i];
            waitCyc(BitCyc);
        end
`ifdef UART_RX_PARITY_EN
        RSRX = par;
        waitCyc(BitCyc);
`else
        if (par) begin
            RSRX = stopBit;
        end
`endif
        RSRX = stopBit;
        waitCyc(BitCyc);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        RSRX = 1'b1;
        rxBus.RX_READY = 1'b0;
        rxBus.OVR_CLR = 1'b0;
        waitCyc(5);
        nVec++;
        if (rxBus.RX_DATA !== 8'h00) begin
            nErr++; $display("FAIL reset_data: got %h want 00", rxBus.RX_DATA);
        end
        nVec++;
        if (rxBus.RX_VALID !== 1'b0) begin
            nErr++; $display("FAIL reset_valid: got %b want 0", rxBus.RX_VALID);
        end
        nVec++;
        if (rxBus.FRAME_ERR !== 1'b0) begin
            nErr++; $display("FAIL reset_frame_err: got %b want 0", rxBus.FRAME_ERR);
        end
        nVec++;
        if (rxBus.PARITY_ERR !== 1'b0) begin
            nErr++; $display("FAIL reset_parity_err: got %b want 0", rxBus.PARITY_ERR);
        end
        nVec++;
        if (rxBus.OVERRUN !== 1'b0) begin
            nErr++; $display("FAIL reset_overrun: got %b want 0", rxBus.OVERRUN);
        end
        RESET = 1'b0;
        waitCyc(5);
    endtask

    task automatic test_single();
        int v0, f0, p0;
        logic [7:0] got, exp;
        rxBus.RX_READY = 1'b1;
        v0 = nValidCyc; f0 = nFe; p0 = nPe;
        expQ.push_back(8'hA5);
        sendFrame(8'hA5, ^8'hA5, 1'b1);
        waitCyc(20);
        nVec++;
        if (rxQ.size() == 0 || expQ.size() == 0) begin
            nErr++; $display("FAIL single_data: got %0d bytes want 1", rxQ.size());
        end else begin
            got = rxQ.pop_front(); exp = expQ.pop_front();
            if (got !== exp) begin
                nErr++; $display("FAIL single_data: got %h want %h", got, exp);
            end
        end
        nVec++;
        if (nValidCyc - v0 != 1) begin
            nErr++; $display("FAIL single_valid_len: got %0d want 1", nValidCyc - v0);
        end
        nVec++;
        if (nFe != f0 || nPe != p0) begin
            nErr++; $display("FAIL single_err_flags: got fe=%0d pe=%0d want 0", nFe - f0, nPe - p0);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] got, exp;
        rxBus.RX_READY = 1'b0;
        expQ.push_back(8'h3C);
        sendFrame(8'h3C, ^8'h3C, 1'b1);
        waitCyc(20);
        sendFrame(8'hC3, ^8'hC3, 1'b1);
        waitCyc(20);
        nVec++;
        if (rxBus.RX_VALID !== 1'b1 || rxBus.RX_DATA !== 8'h3C) begin
            nErr++; $display("FAIL ovr_hold: got v=%b d=%h want v=1 d=3c",
                             rxBus.RX_VALID, rxBus.RX_DATA);
        end
        nVec++;
        if (rxBus.OVERRUN !== 1'b1) begin
            nErr++; $display("FAIL ovr_set: got %b want 1", rxBus.OVERRUN);
        end
        rxBus.OVR_CLR = 1'b1;
        waitCyc(1);
        rxBus.OVR_CLR = 1'b0;
        waitCyc(1);
        nVec++;
        if (rxBus.OVERRUN !== 1'b0 || rxBus.RX_VALID !== 1'b1) begin
            nErr++; $display("FAIL ovr_clr: got ovr=%b v=%b want ovr=0 v=1",
                             rxBus.OVERRUN, rxBus.RX_VALID);
        end
        rxBus.RX_READY = 1'b1;
        waitCyc(2);
        nVec++;
        if (rxBus.RX_VALID !== 1'b0) begin
            nErr++; $display("FAIL ovr_drain_valid: got %b want 0", rxBus.RX_VALID);
        end
        nVec++;
        if (rxQ.size() != 1 || expQ.size() == 0) begin
            nErr++; $display("FAIL ovr_drain_data: got %0d bytes want 1", rxQ.size());
            rxQ.delete();
            expQ.delete();
        end else begin
            got = rxQ.pop_front(); exp = expQ.pop_front();
            if (got !== exp) begin
                nErr++; $display("FAIL ovr_drain_data: got %h want %h", got, exp);
            end
        end
    endtask

    task automatic test_glitch();
        int v0, f0, p0;
        logic [7:0] got, exp;
        v0 = nValidCyc; f0 = nFe; p0 = nPe;
        RSRX = 1'b0;
        waitCyc(5 * Baud);
        RSRX = 1'b1;
        waitCyc(200);
        nVec++;
        if (nValidCyc != v0 || nFe != f0 || nPe != p0) begin
            nErr++; $display("FAIL glitch_quiet: got v=%0d fe=%0d pe=%0d want 0",
                             nValidCyc - v0, nFe - f0, nPe - p0);
        end
        expQ.push_back(8'h69);
        sendFrame(8'h69, ^8'h69, 1'b1);
        waitCyc(20);
        nVec++;
        if (rxQ.size() == 0 || expQ.size() == 0) begin
            nErr++; $display("FAIL glitch_rearm: got %0d bytes want 1", rxQ.size());
        end else begin
            got = rxQ.pop_front(); exp = expQ.pop_front();
            if (got !== exp) begin
                nErr++; $display("FAIL glitch_rearm: got %h want %h", got, exp);
            end
        end
    endtask

    task automatic test_frame_err();
        int v0, f0;
        logic [7:0] got, exp;
        v0 = nValidCyc; f0 = nFe;
        sendFrame(8'h55, ^8'h55, 1'b0);
        waitCyc(40 * Baud);
        RSRX = 1'b1;
        waitCyc(20);
        nVec++;
        if (nFe - f0 != 1) begin
            nErr++; $display("FAIL ferr_pulse: got %0d pulses want 1", nFe - f0);
        end
        nVec++;
        if (nValidCyc != v0) begin
            nErr++; $display("FAIL ferr_no_byte: got %0d valid cycles want 0", nValidCyc - v0);
        end
        expQ.push_back(8'h12);
        sendFrame(8'h12, ^8'h12, 1'b1);
        waitCyc(20);
        nVec++;
        if (rxQ.size() == 0 || expQ.size() == 0 || nFe - f0 != 1) begin
            nErr++; $display("FAIL ferr_recover: got %0d bytes fe=%0d want 1 byte fe=1",
                             rxQ.size(), nFe - f0);
        end else begin
            got = rxQ.pop_front(); exp = expQ.pop_front();
            if (got !== exp) begin
                nErr++; $display("FAIL ferr_recover: got %h want %h", got, exp);
            end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int v0, p0;
        logic [7:0] got, exp;
        expQ.push_back(8'h07);
        sendFrame(8'h07, 1'b1, 1'b1);
        waitCyc(20);
        nVec++;
        if (rxQ.size() == 0 || expQ.size() == 0) begin
            nErr++; $display("FAIL par_good: got %0d bytes want 1", rxQ.size());
        end else begin
            got = rxQ.pop_front(); exp = expQ.pop_front();
            if (got !== exp) begin
                nErr++; $display("FAIL par_good: got %h want %h", got, exp);
            end
        end
        v0 = nValidCyc; p0 = nPe;
        sendFrame(8'h07, 1'b0, 1'b1);
        waitCyc(20);
        nVec++;
        if (nPe - p0 != 1 || nValidCyc != v0) begin
            nErr++; $display("FAIL par_bad: got pe=%0d v=%0d want pe=1 v=0",
                             nPe - p0, nValidCyc - v0);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] got, exp;
        rxBus.RX_READY = 1'b1;
        expQ.push_back(8'h01);
        sendFrame(8'h01, ^8'h01, 1'b1);
        expQ.push_back(8'hFE);
        sendFrame(8'hFE, ^8'hFE, 1'b1);
        waitCyc(20);
        for (int i = 0; i < 2; i++) begin
            nVec++;
            if (rxQ.size() == 0 || expQ.size() == 0) begin
                nErr++; $display("FAIL b2b_byte%0d: got no byte want one", i);
            end else begin
                got = rxQ.pop_front(); exp = expQ.pop_front();
                if (got !== exp) begin
                    nErr++; $display("FAIL b2b_byte%0d: got %h want %h", i, got, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] partial;
        logic [7:0] got, exp;
        partial = 8'h5A;
        rxBus.RX_READY = 1'b0;
        sendFrame(8'h81, ^8'h81, 1'b1);
        waitCyc(10);
        sendFrame(8'h42, ^8'h42, 1'b1);
        waitCyc(10);
        nVec++;
        if (rxBus.RX_VALID !== 1'b1 || rxBus.OVERRUN !== 1'b1) begin
            nErr++; $display("FAIL rstmid_pre: got v=%b ovr=%b want 1 1",
                             rxBus.RX_VALID, rxBus.OVERRUN);
        end
        RSRX = 1'b0;
        waitCyc(BitCyc);
        for (int i = 0; i < 4; i++) begin
            RSRX = partial[i];
            waitCyc(BitCyc);
        end
        RSRX = partial[4];
        waitCyc(BitCyc / 2);
        RESET = 1'b1;
        RSRX = 1'b1;
        waitCyc(3);
        nVec++;
        if (rxBus.RX_DATA !== 8'h00 || rxBus.RX_VALID !== 1'b0 || rxBus.OVERRUN !== 1'b0 ||
            rxBus.FRAME_ERR !== 1'b0 || rxBus.PARITY_ERR !== 1'b0) begin
            nErr++; $display("FAIL rstmid_outputs: got d=%h v=%b ovr=%b fe=%b pe=%b want 00 0 0 0 0",
                             rxBus.RX_DATA, rxBus.RX_VALID, rxBus.OVERRUN,
                             rxBus.FRAME_ERR, rxBus.PARITY_ERR);
        end
        RESET = 1'b0;
        waitCyc(80);
        rxBus.RX_READY = 1'b1;
        expQ.push_back(8'hF0);
        sendFrame(8'hF0, ^8'hF0, 1'b1);
        waitCyc(20);
        nVec++;
        if (rxQ.size() != 1 || expQ.size() == 0) begin
            nErr++; $display("FAIL rstmid_after: got %0d bytes want 1", rxQ.size());
        end else begin
            got = rxQ.pop_front(); exp = expQ.pop_front();
            if (got !== exp) begin
                nErr++; $display("FAIL rstmid_after: got %h want %h", got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_glitch();
        test_frame_err();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver for the AHB-Lite SoC's RsRx pin. It oversamples the asynchronous line at 16x baud, rejects start-bit glitches and recovers 8N1 frames (optionally 8E1). Each recovered byte goes into a one-entry holding register with a valid/ready handshake, which the AHB UART peripheral register block reads. It is the direct consumer of the RsRx serial stream that the UART transmitter drives, including in the system-level TX→RX loopback bench.

## Interface
- BAUD_DIV, default 163: CLK cycles per oversample tick (baud = CLK / (16·BAUD_DIV)); 163 gives ≈19200 baud at 50 MHz; legal range 1..65535
- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- RSRX  in  1  asynchronous serial input, idle high
- RX_DATA  out  8  received byte, stable while RX_VALID=1
- RX_VALID  out  1  byte available in holding register
- RX_READY  in  1  consumer accepts byte when RX_VALID & RX_READY
- FRAME_ERR  out  1  one-cycle pulse: stop bit sampled low
- PARITY_ERR  out  1  one-cycle pulse: parity mismatch (constant 0 when parity compiled out)
- OVERRUN  out  1  sticky: byte completed while holding register full
- OVR_CLR  in  1  clears OVERRUN (takes priority over a same-cycle set)

## Operation
- RSRX passes through a 2-flop synchronizer, then a falling-edge detector; rx_s denotes the synchronized value.
- Tick generator: 16-bit counter counts 0..BAUD_DIV-1 and emits a 1-cycle tick at wrap. It is forced to 0 on start-edge detection so sampling aligns to the edge.
- Per-bit 4-bit tick counter; a bit is sampled at tick count 7 (mid-bit) for START and at tick 15 for the other states.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP, BREAK.
  - IDLE: falling edge on rx_s → START.
  - START: at 8th tick, rx_s=1 → IDLE (glitch, nothing reported); rx_s=0 → DATA, bit index=0, tick counter=0.
  - DATA: every 16 ticks sample rx_s into shift register, LSB first; after bit 7 → PARITY or STOP.
  - PARITY: sample the bit and compare with even parity of the 8 data bits.
  - STOP, rx_s=1: frame good. If parity checked and mismatched → PARITY_ERR pulse, byte discarded, then IDLE. Otherwise deliver the byte, then IDLE.
  - STOP, rx_s=0: FRAME_ERR pulse, byte discarded → BREAK.
  - BREAK: wait for rx_s=1, then IDLE (no re-arm on a held-low line).
- Delivery:
  - RX_VALID=0 or accepted same cycle → load RX_DATA, RX_VALID=1.
  - RX_VALID=1 and RX_READY=0 → byte dropped, OVERRUN set; RX_DATA unchanged.
- Handshake: RX_VALID drops the cycle after RX_VALID&RX_READY, unless a new byte loads in that same cycle, in which case it stays 1 with new data.
- RESET in any state aborts the frame: FSM→IDLE, all counters 0, synchronizer flops=1.

## Timing
- Reset values: RX_DATA=8'h00, RX_VALID=0, FRAME_ERR=0, PARITY_ERR=0, OVERRUN=0.
- Synchronizer latency is 2 CLK; edge detect adds 1.
- RX_VALID rises 1 CLK after the stop-bit sample tick. Nominal latency from start edge is ≈(8+16·9)·BAUD_DIV+3 CLK for 8N1; add 16·BAUD_DIV with parity.
- Error pulses assert in the same cycle RX_VALID would have risen.
- Tolerates ±3% baud mismatch.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state present, even parity checked, frame is 11 bits, PARITY_ERR live.
- UART_RX_PARITY_EN undefined: 8N1 only, PARITY state absent, PARITY_ERR tied 0.

## Test plan
- BAUD_DIV=4, send 8'hA5 8N1, RX_READY=1 → RX_DATA=8'hA5, RX_VALID for exactly 1 cycle, no error flags.
- Send 8'h3C then 8'hC3 with RX_READY=0 → RX_DATA stays 8'h3C, OVERRUN=1. Pulse OVR_CLR → OVERRUN=0. Raise RX_READY → RX_VALID=0.
- Low glitch of 5·BAUD_DIV cycles on idle line → FSM returns to IDLE, no RX_VALID, no error.
- Send 8'h55 with stop bit forced 0, line held low 40·BAUD_DIV cycles, then a valid 8'h12 → one FRAME_ERR pulse, no byte for the bad frame, then RX_DATA=8'h12.
- With UART_RX_PARITY_EN: 8'h07 with parity bit 1 → RX_DATA=8'h07. Same byte with parity bit 0 → PARITY_ERR pulse, no RX_VALID.
- Assert RESET mid DATA bit 4 → all outputs at reset values. The following complete frame 8'hF0 is received correctly.
